// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph codes and nibble-to-segment encoder for the 7-seg scanner
package seven_seg_pkg;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1011000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A = SEG_BLANK;
    localparam logic [6:0] SEG_B = 7'b0111111;
    localparam logic [6:0] SEG_C = 7'b0001001;
    localparam logic [6:0] SEG_D = 7'b1000111;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001100;
    localparam logic [6:0] SEG_ERR = 7'b1110011;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        case (nibble)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            4'hF: return SEG_F;
            default: return SEG_ERR;
        endcase
    endfunction
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational nibble-to-segment decoder
module seg_glyph_rom
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb seg = seg_encode(nibble);
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed N-digit 7-seg driver with LZ suppression, blink and ghost guard
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic                      lz_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      frame_start
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  blink_on;
    logic [DW-1:0]         disp_reg, pend_reg, disp_n;
    logic                  pend_vld, blink_n, tc, blank;
    logic [NUM_DIGITS-1:0] lz, an_n;
    logic [3:0]            nib;
    logic [6:0]            glyph, seg_n;

    // The registered frame_start cycle is the ghost slot of digit 0, so the
    // display word is swapped there and digit 0 is first lit with fresh data.
    always_comb begin
        tc      = presc == P_LAST;
        disp_n  = frame_start ? (load ? value : (pend_vld ? pend_reg : disp_reg)) : disp_reg;
        blink_n = (frame_start && fcnt == F_LAST) ? ~blink_on : blink_on;
        nib     = disp_n[{idx, 2'b00} +: 4];
        blank   = presc == '0 || (!blink_n && blink_mask[idx]) || lz[idx];
        an_n    = presc == '0 ? '1 : ~(NUM_DIGITS'(1) << idx);
        seg_n   = blank ? SEG_BLANK : glyph;
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        assign lz[k] = (k != 0) && lz_en && (disp_n[DW-1:4*k] == '0);
    end

    seg_glyph_rom u_rom (.nibble(nib), .seg(glyph));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_on    <= 1'b1;
            disp_reg    <= '0;
            pend_reg    <= '0;
            pend_vld    <= 1'b0;
            an          <= '1;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            presc       <= tc ? '0 : presc + PW'(1);
            if (tc) idx <= idx == I_LAST ? '0 : idx + IW'(1);
            if (frame_start) fcnt <= fcnt == F_LAST ? '0 : fcnt + FW'(1);
            blink_on    <= blink_n;
            disp_reg    <= disp_n;
            if (load && !frame_start) begin
                pend_reg <= value;
                pend_vld <= 1'b1;
            end else if (frame_start) begin
                pend_vld <= 1'b0;
            end
            an          <= an_n;
            seg         <= seg_n;
            frame_start <= presc == '0 && idx == '0;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: randomized self-checking bench against a frame-level display model
module tb_seven_seg_scan;
    localparam int N = 4, R = 4, B = 2, F = N * R;

    logic clk = 0, rst = 1, load = 0, lz_en = 0;
    logic [15:0] value = '0;
    logic [3:0] blink_mask = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic frame_start;

    int checks = 0, passes = 0;
    int v = 0, frames = 0;
    logic [15:0] shown = '0, pend = '0;
    logic pv = 0, plz = 0;
    logic [3:0] pmask = '0;
    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                              7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111,
                              7'b0001001, 7'b1000111, 7'b0000110, 7'b0001100};

    seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(B)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .lz_en(lz_en),
        .blink_mask(blink_mask), .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // v = visible cycle since reset release (0 = still showing reset values)
    function automatic logic [3:0] e_an();
        if (v == 0 || (v - 1) % R == 0) return 4'hF;
        return ~(4'b0001 << (((v - 1) / R) % N));
    endfunction

    function automatic logic e_fs();
        return v > 0 && (v - 1) % F == 0;
    endfunction

    function automatic logic [6:0] e_seg();
        int d;
        logic [15:0] rest;
        if (v == 0 || (v - 1) % R == 0) return 7'h7F;
        d = ((v - 1) / R) % N;
        rest = shown >> (4 * d);
        if (((frames / B) % 2) == 1 && pmask[d]) return 7'h7F;
        if (plz && d != 0 && rest == 0) return 7'h7F;
        return glyph[rest[3:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            v = 0; frames = 0; shown = '0; pend = '0; pv = 0;
        end else begin
            if (v > 0 && (v - 1) % F == 0) begin
                shown = load ? value : (pv ? pend : shown);
                pv = 0;
                frames++;
            end else if (load) begin
                pend = value;
                pv = 1;
            end
            pmask = blink_mask;
            plz = lz_en;
            v++;
        end
        @(negedge clk);
    endtask

    task automatic wait_fs();
        int n = 0;
        while (!frame_start && n < 2 * F) begin tick(); n++; end
        checks++;
        if (!frame_start) $display("FAIL wait_fs frame_start=%b required=1 after %0d cycles", frame_start, n);
        else passes++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0})
                $display("FAIL reset_hold got=%b required=%b", {an, seg, frame_start}, {4'hF, 7'h7F, 1'b0});
            else passes++;
        end
        rst = 0;
        for (int i = 0; i < 2 * F + 1; i++) begin
            checks++;
            if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                $display("FAIL reset_walk v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
            else passes++;
            tick();
        end
    endtask

    task automatic test_load();
        wait_fs();
        tick(); tick();
        value = 16'h1234; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 2 * F + 3; i++) begin
            checks++;
            if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                $display("FAIL load v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
            else passes++;
            tick();
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        lz_en = 1;
        for (int j = 0; j < 2; j++) begin
            wait_fs();
            tick();
            value = vals[j]; load = 1;
            tick();
            load = 0;
            for (int i = 0; i < 2 * F; i++) begin
                checks++;
                if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                    $display("FAIL lz v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
                else passes++;
                tick();
            end
        end
        lz_en = 0;
    endtask

    task automatic test_back_to_back();
        wait_fs();
        tick();
        value = 16'h1111; load = 1;
        tick();
        load = 0;
        tick();
        value = 16'h2222; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 2 * F; i++) begin
            checks++;
            if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                $display("FAIL back_to_back v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
            else passes++;
            tick();
        end
        wait_fs();
        value = 16'h3333; load = 1;
        tick();
        load = 0;
        checks++;
        if (seg !== 7'b0110000) $display("FAIL load_on_frame_start seg=%b required=%b", seg, 7'b0110000);
        else passes++;
        for (int i = 0; i < F; i++) begin
            checks++;
            if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                $display("FAIL same_frame v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
            else passes++;
            tick();
        end
    endtask

    task automatic test_blink();
        blink_mask = 4'b0001;
        wait_fs();
        tick();
        value = 16'hBCDE; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 6 * F; i++) begin
            checks++;
            if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                $display("FAIL blink v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
            else passes++;
            tick();
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            value = 16'($urandom);
            lz_en = 1'($urandom);
            blink_mask = 4'($urandom);
            load = ($urandom % 3) == 0;
            tick();
            load = 0;
            for (int i = $urandom_range(1, 12); i > 0; i--) begin
                checks++;
                if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                    $display("FAIL random v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
                else passes++;
                tick();
            end
        end
        lz_en = 0;
        blink_mask = '0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        wait_fs();
        tick();
        value = 16'h9876; load = 1;
        tick();
        load = 0;
        while (an !== 4'b1011 && n < 2 * F) begin tick(); n++; end
        checks++;
        if (an !== 4'b1011) $display("FAIL reach_digit2 an=%b required=1011", an);
        else passes++;
        #2 rst = 1;
        #1;
        checks++;
        if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0})
            $display("FAIL async_reset got=%b required=%b", {an, seg, frame_start}, {4'hF, 7'h7F, 1'b0});
        else passes++;
        tick();
        rst = 0;
        for (int i = 0; i < 2 * F + 1; i++) begin
            checks++;
            if ({an, seg, frame_start} !== {e_an(), e_seg(), e_fs()})
                $display("FAIL after_reset v=%0d got=%b required=%b", v, {an, seg, frame_start}, {e_an(), e_seg(), e_fs()});
            else passes++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_lz();
        test_back_to_back();
        test_blink();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
